// File: rtl/mmd_divider.sv
// rtl/mmd_divider.sv - multi-modulus divider with period counter; optional input clamp under M216A_MMD_CLAMP_EN
module mmd_divider (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] div_in,
   output logic       mod_adv,
   output logic       tc,
   output logic       div_out,
   output logic [3:0] ratio_q,
   output logic       range_err
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] ratio_d;
   logic       div_out_q, div_out_d;
   logic       tc_q, tc_d;
   logic       mod_adv_q, mod_adv_d;
   logic       load;
   logic [3:0] n_smp;

   // Number of cnt values in the low half of a period: cnt >= half means high.
   // A ratio of 0 stands for a 16-cycle period.
   function automatic logic [3:0] half_of(input logic [3:0] n);
      return (n == 4'd0) ? 4'd8 : {1'b0, n[3:1]};
   endfunction

`ifdef M216A_MMD_CLAMP_EN
   logic n_oor;
   logic range_err_q, range_err_d;

   // Clamp the sampled ratio into the supported range and flag any correction
   always_comb begin
      n_smp = div_in;
      n_oor = 1'b0;
      if (div_in < 4'd3) begin
         n_smp = 4'd3;
         n_oor = 1'b1;
      end else if (div_in > 4'd11) begin
         n_smp = 4'd11;
         n_oor = 1'b1;
      end
   end

   // Sticky out-of-range flag, set only when a clamped value is actually loaded
   always_comb begin
      range_err_d = range_err_q | (load & n_oor);
   end

   // Out-of-range flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) range_err_q <= 1'b0;
      else        range_err_q <= range_err_d;
   end

   assign range_err = range_err_q;
`else
   // Ratio passes through unmodified
   always_comb begin
      n_smp = div_in;
   end

   assign range_err = 1'b0;
`endif

   // Next-state, counter and registered-output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ratio_d   = ratio_q;
      div_out_d = 1'b0;
      tc_d      = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) load = 1'b1;
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               load = 1'b1;
            end else begin
               cnt_d     = cnt_q - 4'd1;
               div_out_d = (cnt_d >= half_of(ratio_q));
               tc_d      = (cnt_d == 4'd0);
            end
         end
         default: state_d = IDLE;
      endcase
      // Starting a period (from IDLE or back-to-back) samples the new ratio
      if (load) begin
         state_d   = RUN;
         ratio_d   = n_smp;
         cnt_d     = n_smp - 4'd1;
         div_out_d = 1'b1;
         tc_d      = (n_smp == 4'd1);
      end
      mod_adv_d = tc_d;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         ratio_q   <= 4'd0;
         div_out_q <= 1'b0;
         tc_q      <= 1'b0;
         mod_adv_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ratio_q   <= ratio_d;
         div_out_q <= div_out_d;
         tc_q      <= tc_d;
         mod_adv_q <= mod_adv_d;
      end
   end

   assign div_out = div_out_q;
   assign tc      = tc_q;
   assign mod_adv = mod_adv_q;

endmodule

// File: tb/tb_mmd_divider.sv
// tb/tb_mmd_divider.sv - randomized bench for mmd_divider against a period-position model
module tb_mmd_divider;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] div_in;
   logic       mod_adv;
   logic       tc;
   logic       div_out;
   logic [3:0] ratio_q;
   logic       range_err;

   int n_cmp;
   int n_bad;

   // Model: running flag, position k within a period of length m_len
   bit         m_run;
   int         m_k;
   int         m_len;
   logic [3:0] m_ratio;
   bit         m_err;

   mmd_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .div_in    (div_in),
      .mod_adv   (mod_adv),
      .tc        (tc),
      .div_out   (div_out),
      .ratio_q   (ratio_q),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic m_reset();
      m_run   = 1'b0;
      m_k     = 0;
      m_len   = 0;
      m_ratio = 4'd0;
      m_err   = 1'b0;
   endtask

   task automatic m_load(input logic [3:0] d);
      logic [3:0] n;
      n = d;
`ifdef M216A_MMD_CLAMP_EN
      if (d < 4'd3) begin
         n = 4'd3;
         m_err = 1'b1;
      end else if (d > 4'd11) begin
         n = 4'd11;
         m_err = 1'b1;
      end
`endif
      m_ratio = n;
      m_len   = (n == 4'd0) ? 16 : int'(n);
      m_k     = 0;
      m_run   = 1'b1;
   endtask

   task automatic check_outputs();
      check("div_out",   32'(div_out),   32'(m_run && (m_k < (m_len + 1) / 2)));
      check("tc",        32'(tc),        32'(m_run && (m_k == m_len - 1)));
      check("mod_adv",   32'(mod_adv),   32'(m_run && (m_k == m_len - 1)));
      check("ratio_q",   32'(ratio_q),   32'(m_ratio));
      check("range_err", 32'(range_err), 32'(m_err));
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare
   task automatic tick();
      @(posedge clk);
      if (!m_run) begin
         if (en) m_load(div_in);
      end else if (!en) begin
         m_run = 1'b0;
      end else if (m_k == m_len - 1) begin
         m_load(div_in);
      end else begin
         m_k++;
      end
      #1;
      check_outputs();
   endtask

   task automatic go_idle();
      en = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst_n  = 1'b0;
      en     = 1'b0;
      div_in = 4'd0;
      m_reset();
      #23;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();

      // Constant ratio 4
      en = 1'b1;
      div_in = 4'd4;
      for (int i = 0; i < 13; i++) tick();

      // Ratio 3 switched to 11 one cycle after the first mod_adv
      go_idle();
      en = 1'b1;
      div_in = 4'd3;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (m_run && m_k == 0 && m_ratio == 4'd3 && i > 2) div_in = 4'd11;
      end

      // Ratio 5 with a one-cycle glitch to 9 at k=2
      go_idle();
      en = 1'b1;
      div_in = 4'd5;
      for (int i = 0; i < 20; i++) begin
         tick();
         div_in = (m_run && m_k == 1) ? 4'd9 : 4'd5;
      end
      check("ratio_never_9", 32'(ratio_q), 32'd5);

      // Enable dropped at k=2 of a 7-cycle period, then restarted
      go_idle();
      en = 1'b1;
      div_in = 4'd7;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (m_run && m_k == 2 && i > 0) en = 1'b0;
      end
      tick();
      en = 1'b1;
      for (int i = 0; i < 10; i++) tick();

      // Out-of-range ratios
      go_idle();
      en = 1'b1;
      div_in = 4'd1;
      for (int i = 0; i < 8; i++) tick();
      div_in = 4'd15;
      for (int i = 0; i < 14; i++) tick();
      div_in = 4'd0;
      for (int i = 0; i < 36; i++) tick();
      div_in = 4'd6;
      for (int i = 0; i < 4; i++) tick();

      // Asynchronous reset between edges, then restart with enable high
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      check("rst_div_out", 32'(div_out), 32'd0);
      check("rst_tc",      32'(tc),      32'd0);
      check("rst_mod_adv", 32'(mod_adv), 32'd0);
      check("rst_ratio",   32'(ratio_q), 32'd0);
      check("rst_err",     32'(range_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      div_in = 4'd5;
      for (int i = 0; i < 12; i++) tick();

      // Random ratios and occasional enable drops
      for (int i = 0; i < 500; i++) begin
         en     = ($urandom_range(0, 15) != 0);
         div_in = 4'($urandom_range(0, 15));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mmd_divider.md
MMD_DIVIDER -- requirements
Module: mmd_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  system clock (500 MHz), all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run enable; 0 = idle, 1 = divide.
REQ-005 div_in  input  4  instantaneous divide ratio N from the MASH modulator output (nominal 3..11).
REQ-006 mod_adv  output  1  one-cycle pulse; upstream modulator advances one step on the edge ending this cycle.
REQ-007 tc  output  1  terminal-count pulse, last cycle of each divide period.
REQ-008 div_out  output  1  divided clock, registered.
REQ-009 ratio_q  output  4  ratio N active for the current period.
REQ-010 range_err  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-011 FSM states SHALL be IDLE and RUN; a 4-bit down-counter cnt SHALL track position in the period.
REQ-012 IDLE, en=0: cnt held, div_out=0, tc=0, mod_adv=0, ratio_q held.
REQ-013 IDLE, en=1 at an edge: at that edge ratio_q<=N(div_in), cnt<=N-1 (mod 16), state<=RUN, div_out<=1; the following cycle is period index k=0.
REQ-014 RUN: period of N cycles indexed k=0..N-1; cnt decrements by 1 per cycle; N=0 SHALL yield a 16-cycle period (cnt loads 15).
REQ-015 div_out SHALL be 1 for k < ceil(N/2) and 0 otherwise (N=3: 1,1,0; N=4: 1,1,0,0; N=11: 6 high, 5 low; N=1: constant 1; N=0: 8 high, 8 low).
REQ-016 tc and mod_adv SHALL both be 1 exactly in cycle k=N-1 and 0 otherwise; both registered, no combinational path from any input.
REQ-017 At the edge ending cycle k=N-1, div_in SHALL be sampled into ratio_q and cnt reloaded; the next period starts with no gap cycle.
REQ-018 div_in changes at any cycle other than k=N-1 SHALL have no effect on the current period.
REQ-019 en sampled 0 while in RUN: next cycle state=IDLE, div_out=0, tc=0, mod_adv=0, partial period discarded; re-enable restarts at k=0 per REQ-013.
REQ-020 en=0 at the tc edge: IDLE wins, no reload, ratio_q unchanged.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, cnt=0, div_out=0, tc=0, mod_adv=0, ratio_q=0, range_err=0, including mid-period.
REQ-022 After rst_n deasserts, the first active edge SHALL be treated as IDLE behaviour per REQ-012/REQ-013.

Configuration
REQ-023 Macro M216A_MMD_CLAMP_EN defined: each sampled div_in SHALL be clamped to [3,11] (0..2 -> 3, 12..15 -> 11) before use and before storage in ratio_q; any clamped sample SHALL set range_err=1 until reset.
REQ-024 Macro undefined: div_in SHALL be used unmodified (including 0 -> 16-cycle and 1 -> 1-cycle periods) and range_err SHALL be tied to 0.

Verification
REQ-025 Reset, en=1, div_in=4 constant -> div_out 1,1,0,0 repeating; tc=mod_adv=1 every 4th cycle; ratio_q=4.
REQ-026 div_in=3, switched to 11 in the cycle after the first mod_adv -> periods 3 (div_out 1,1,0) then 11 (6 high, 5 low); no gap cycle at boundary.
REQ-027 div_in=5, pulsed to 9 at k=2 only -> period stays 5; ratio_q never 9.
REQ-028 en dropped at k=2 of an N=7 period -> next cycle div_out=0, tc=0; en raised again -> new period restarts at k=0 with 4 high, 3 low.
REQ-029 With M216A_MMD_CLAMP_EN: div_in=1 -> period 3, range_err=1 and stays 1; div_in=15 -> period 11. Without: div_in=0 -> period 16, range_err=0.
REQ-030 rst_n asserted asynchronously mid-RUN (between edges) -> all outputs 0 before next edge; after release with en=1, normal start per REQ-013.
